// File: rtl/y_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// y_ctrl_pkg: shared opcodes, ALU encodings and FSM types for y_seq_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package y_ctrl_pkg;

  localparam logic [6:0] OPC_R   = 7'h33;
  localparam logic [6:0] OPC_I   = 7'h13;
  localparam logic [6:0] OPC_LD  = 7'h03;
  localparam logic [6:0] OPC_ST  = 7'h23;
  localparam logic [6:0] OPC_BR  = 7'h63;
  localparam logic [6:0] OPC_JAL = 7'h6F;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_BR, CLS_JAL
  } cls_e;

  typedef enum logic [1:0] {
    PC_SEL_P4, PC_SEL_BR, PC_SEL_J
  } pc_sel_e;

  // {valid, op} for the funct3 values shared by R-type and I-ALU
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] funct3);
    logic [3:0] r;
    case (funct3)
      3'b000:  r = {1'b1, ALU_ADD};
      3'b111:  r = {1'b1, ALU_AND};
      3'b110:  r = {1'b1, ALU_OR};
      3'b010:  r = {1'b1, ALU_SLT};
      default: r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/y_ctrl_dec.sv
// ---------------------------------------------------------------------------
// y_ctrl_dec: combinational instruction decode to class, ALU op and ALUSrc
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module y_ctrl_dec
  import y_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output cls_e       cls,
  output logic [2:0] op,
  output logic       alu_src,
  output logic       illegal
);

  logic [3:0] alu_f;
  assign alu_f = alu_from_funct3(funct3);

  always_comb begin
    cls     = CLS_NONE;
    op      = ALU_ADD;
    alu_src = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        if (funct3 == 3'b000 && funct7_5) begin
          cls = CLS_R;
          op  = ALU_SUB;
        end else if (alu_f[3]) begin
          cls = CLS_R;
          op  = alu_f[2:0];
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_I: begin
        if (alu_f[3]) begin
          cls     = CLS_I;
          op      = alu_f[2:0];
          alu_src = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LD: begin
        cls     = CLS_LD;
        alu_src = 1'b1;
      end
      OPC_ST: begin
        cls     = CLS_ST;
        alu_src = 1'b1;
      end
      OPC_BR: begin
        if (funct3 == 3'b000) begin
          cls = CLS_BR;
          op  = ALU_SUB;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_JAL: cls = CLS_JAL;
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/y_seq_ctrl.sv
// ---------------------------------------------------------------------------
// y_seq_ctrl: multi-cycle control sequencer for the yIF/yID/yEX/yDM/yWB path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module y_seq_ctrl
  import y_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0028,
  parameter logic [15:0] MAX_INS  = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ins,
  input  logic [31:0] PCp4,
  input  logic [31:0] branch,
  input  logic [31:0] jTarget,
  input  logic        zero,
  output logic [31:0] PC,
  output logic        RegWrite,
  output logic        ALUSrc,
  output logic        Mem2Reg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  op,
  output logic        link,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] retired
);

  state_e     state, state_nx;
  logic [31:0] ir;
  cls_e       cls;
  logic [2:0] dec_op;
  logic       dec_alu_src;
  logic       dec_illegal;
  logic       last;
  logic       set_illegal;
  logic       at_limit;
  pc_sel_e    pc_sel;

  y_ctrl_dec u_dec (
    .opcode   (ir[6:0]),
    .funct3   (ir[14:12]),
    .funct7_5 (ir[30]),
    .cls      (cls),
    .op       (dec_op),
    .alu_src  (dec_alu_src),
    .illegal  (dec_illegal)
  );

  assign at_limit = (MAX_INS != 16'd0) && ((retired + 16'd1) == MAX_INS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    RegWrite    = 1'b0;
    ALUSrc      = 1'b0;
    Mem2Reg     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    op          = ALU_ADD;
    link        = 1'b0;
    busy        = 1'b1;
    last        = 1'b0;
    set_illegal = 1'b0;
    pc_sel      = PC_SEL_P4;
    case (state)
      S_IDLE, S_HALT: begin
        busy = 1'b0;
        if (start) state_nx = S_IF;
      end
      S_IF: state_nx = S_ID;
      S_ID: begin
        if (ir == 32'h0) begin
          state_nx = S_HALT;
        end else if (dec_illegal) begin
          state_nx    = S_HALT;
          set_illegal = 1'b1;
        end else begin
          state_nx = S_EX;
        end
      end
      S_EX: begin
        case (cls)
          CLS_BR:         last = 1'b1;
          CLS_LD, CLS_ST: state_nx = S_MEM;
          default:        state_nx = S_WB;
        endcase
      end
      S_MEM: begin
        MemRead  = (cls == CLS_LD);
        MemWrite = (cls == CLS_ST);
        if (cls == CLS_LD) state_nx = S_WB;
        else               last = 1'b1;
      end
      S_WB: begin
        RegWrite = 1'b1;
        last     = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase

    // Datapath selects are held steady for the whole active part of the sequence
    if (state inside {S_ID, S_EX, S_MEM, S_WB}) begin
      ALUSrc  = dec_alu_src;
      op      = dec_op;
      link    = (cls == CLS_JAL);
      Mem2Reg = (cls == CLS_LD);
    end

    if (last) begin
      if (cls == CLS_BR && zero) pc_sel = PC_SEL_BR;
      else if (cls == CLS_JAL)   pc_sel = PC_SEL_J;
      state_nx = at_limit ? S_HALT : S_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC      <= RESET_PC;
      ir      <= 32'h0;
      retired <= 16'd0;
      illegal <= 1'b0;
    end else begin
      if ((state == S_IDLE || state == S_HALT) && start) begin
        PC      <= RESET_PC;
        retired <= 16'd0;
        illegal <= 1'b0;
      end
      if (state == S_IF) ir <= ins;
      if (set_illegal)   illegal <= 1'b1;
      if (last) begin
        retired <= retired + 16'd1;
        case (pc_sel)
          PC_SEL_BR: PC <= branch;
          PC_SEL_J:  PC <= jTarget;
          default:   PC <= PCp4;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
